// File: rtl/sar_pkg.sv
// sar_pkg: shared constants and FSM state type for the SAR word collector.
package sar_pkg;
  localparam int BIT_ADC_DEF = 8;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, SAMPLE, SKIP, SHIFT, PUSH} state_t;
endpackage

// File: rtl/sar_word_fifo.sv
// sar_word_fifo: first-word-fall-through FIFO whose head is a flop, so it can drive outputs directly.
module sar_word_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic r_valid;
  logic w_pop, w_push;
  logic [CW-1:0] w_widx, w_cnt_nxt;
  assign w_pop = i_pop & r_valid;
  assign w_push = i_push & (~o_full | w_pop);
  assign w_widx = w_pop ? r_cnt - CW'(1) : r_cnt;
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = ~r_valid;
  assign o_head = r_mem[0];
  // Entries shift toward index 0 on pop; a same-edge push lands in the slot freed by the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
      r_cnt <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_pop)
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      if (w_push) r_mem[w_widx[AW-1:0]] <= i_din;
      r_cnt <= w_cnt_nxt;
      r_valid <= w_cnt_nxt != '0;
    end
  end
endmodule

// File: rtl/sar_word_collector.sv
// sar_word_collector: deserializes MSB-first SAR results into words and queues them in a FIFO.
module sar_word_collector import sar_pkg::*; #(
  parameter int BIT_ADC = BIT_ADC_DEF,
  parameter int BIT_OFFSET = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               XRST,
  input  logic               SAR_SC,
  input  logic               SAR_DOUT,
  output logic [BIT_ADC-1:0] DATA_OUT,
  output logic               DATA_VALID,
  input  logic               DATA_READY,
  output logic               OVERFLOW,
  input  logic               CLR_OVF,
  output logic               FRAME_ERR,
  output logic [CNT_W-1:0]   SAMPLE_CNT
);
  localparam int BW = $clog2(BIT_ADC + 1);
  state_t r_state, w_next;
  logic [3:0] r_skip;
  logic [BW-1:0] r_bit;
  logic [BIT_ADC-1:0] r_sh;
  logic r_ovf, r_ferr;
  logic [CNT_W-1:0] r_cnt;
  logic w_abort, w_shift, w_push, w_full, w_empty, w_accept, w_drop;
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_abort = 1'b0;
    w_shift = 1'b0;
    w_push = 1'b0;
    case (r_state)
      IDLE: w_next = SAR_SC ? SAMPLE : IDLE;
      SAMPLE: w_next = SAR_SC ? SAMPLE : (BIT_OFFSET == 0) ? SHIFT : SKIP;
      SKIP: begin
        w_abort = SAR_SC;
        w_next = SAR_SC ? SAMPLE : (r_skip == 4'(BIT_OFFSET - 1)) ? SHIFT : SKIP;
      end
      SHIFT: begin
        w_abort = SAR_SC;
        w_shift = ~SAR_SC;
        w_next = SAR_SC ? SAMPLE : (r_bit == BW'(BIT_ADC - 1)) ? PUSH : SHIFT;
      end
      PUSH: begin
        w_push = 1'b1;
        w_next = SAR_SC ? SAMPLE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // DATA_READY doubles as pop; a full FIFO still accepts when it pops on the same edge.
  assign w_accept = w_push & (~w_full | DATA_READY);
  assign w_drop = w_push & w_full & ~DATA_READY;
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_skip <= '0;
      r_bit <= '0;
      r_sh <= '0;
      r_ovf <= 1'b0;
      r_ferr <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_skip <= (r_state == SKIP) ? r_skip + 4'd1 : 4'd0;
      r_bit <= w_shift ? r_bit + BW'(1) : '0;
      r_sh <= w_abort ? '0 : w_shift ? {r_sh[BIT_ADC-2:0], SAR_DOUT} : r_sh;
      r_ovf <= w_drop | (r_ovf & ~CLR_OVF);
      r_ferr <= w_abort;
      r_cnt <= r_cnt + CNT_W'(w_accept);
    end
  end
  sar_word_fifo #(.W(BIT_ADC), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(XRST),
    .i_push(w_push),
    .i_din(r_sh),
    .i_pop(DATA_READY),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_head(DATA_OUT)
  );
  assign DATA_VALID = ~w_empty;
  assign OVERFLOW = r_ovf;
  assign FRAME_ERR = r_ferr;
  assign SAMPLE_CNT = r_cnt;
endmodule

// File: tb/tb_sar_word_collector.sv
// tb_sar_word_collector: directed and random frames checked against a queue-based model of the collector.
module tb_sar_word_collector;
  localparam int BA = 8;
  localparam int BO = 1;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic xrst, sc, dout, rdy, clr;
  logic [BA-1:0] data_out;
  logic data_valid, overflow, frame_err;
  logic [15:0] sample_cnt;
  logic sc0, dout0, rdy0, clr0;
  logic [BA-1:0] data_out0;
  logic data_valid0, overflow0, frame_err0;
  logic [15:0] sample_cnt0;
  logic [BA-1:0] q[$];
  logic [15:0] exp_cnt;
  bit exp_ovf;
  int ncmp = 0, nfail = 0;
  always #5 clk = ~clk;
  sar_word_collector #(.BIT_ADC(BA), .BIT_OFFSET(BO), .FIFO_DEPTH(DEPTH)) u_dut (
    .CLK(clk), .XRST(xrst), .SAR_SC(sc), .SAR_DOUT(dout), .DATA_OUT(data_out),
    .DATA_VALID(data_valid), .DATA_READY(rdy), .OVERFLOW(overflow), .CLR_OVF(clr),
    .FRAME_ERR(frame_err), .SAMPLE_CNT(sample_cnt));
  sar_word_collector #(.BIT_ADC(BA), .BIT_OFFSET(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .CLK(clk), .XRST(xrst), .SAR_SC(sc0), .SAR_DOUT(dout0), .DATA_OUT(data_out0),
    .DATA_VALID(data_valid0), .DATA_READY(rdy0), .OVERFLOW(overflow0), .CLR_OVF(clr0),
    .FRAME_ERR(frame_err0), .SAMPLE_CNT(sample_cnt0));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input bit ferr);
    chk("valid", data_valid, q.size() > 0);
    if (q.size() > 0) chk("data", data_out, q[0]);
    chk("count", sample_cnt, exp_cnt);
    chk("overflow", overflow, exp_ovf);
    chk("frame_err", frame_err, ferr);
  endtask
  // One clock edge: the model pops, then pushes, using the inputs present at the edge.
  task automatic tick(input bit push, input logic [BA-1:0] w, input bit ferr);
    bit pop, full, set;
    @(posedge clk);
    pop = rdy && q.size() > 0;
    full = q.size() == DEPTH;
    set = 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!full || pop) begin
        q.push_back(w);
        exp_cnt++;
      end else set = 1;
    end
    exp_ovf = set ? 1'b1 : clr ? 1'b0 : exp_ovf;
    #1;
    check_all(ferr);
  endtask
  task automatic drive(input int mode, input bit is_push);
    rdy = mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom) : mode == 3 ? is_push : 1'b0;
    clr = mode == 2 ? ($urandom_range(0, 5) == 0) : mode == 4 ? is_push : 1'b0;
  endtask
  task automatic frame(input logic [BA-1:0] w, input bit first_hi, input bit last_hi, input int mode);
    if (first_hi) begin
      sc = 1; drive(mode, 0); tick(0, 0, 0);
    end
    sc = 0; drive(mode, 0); tick(0, 0, 0);
    repeat (BO) begin
      dout = 1'($urandom); drive(mode, 0); tick(0, 0, 0);
    end
    for (int k = BA - 1; k >= 0; k--) begin
      dout = w[k]; drive(mode, 0); tick(0, 0, 0);
    end
    sc = last_hi; drive(mode, 1); tick(1, w, 0);
  endtask
  task automatic abort_frame(input bit first_hi, input int nb, input int mode);
    if (first_hi) begin
      sc = 1; drive(mode, 0); tick(0, 0, 0);
    end
    sc = 0; drive(mode, 0); tick(0, 0, 0);
    repeat (BO + nb) begin
      dout = 1'($urandom); drive(mode, 0); tick(0, 0, 0);
    end
    sc = 1; drive(mode, 0); tick(0, 0, 1);
  endtask
  task automatic drain();
    rdy = 1; clr = 0;
    repeat (DEPTH + 1) tick(0, 0, 0);
    rdy = 0;
  endtask
  initial begin
    bit hi;
    logic [BA-1:0] w;
    xrst = 0; sc = 0; dout = 0; rdy = 0; clr = 0;
    sc0 = 0; dout0 = 0; rdy0 = 0; clr0 = 0;
    exp_cnt = 0; exp_ovf = 0;
    #2;
    chk("rst_data", data_out, 0);
    check_all(0);
    @(posedge clk); @(posedge clk); #1 xrst = 1;
    // Zero-offset instance: MSB is the bit present one edge after t0; 0 at t0 guards against early capture.
    sc0 = 1; @(posedge clk); #1 sc0 = 0; dout0 = 0;
    @(posedge clk); #1;
    for (int k = 0; k < BA; k++) begin
      dout0 = 1; @(posedge clk); #1;
    end
    dout0 = 0;
    chk("bo0_valid_early", data_valid0, 0);
    @(posedge clk); #1;
    chk("bo0_valid", data_valid0, 1);
    chk("bo0_data", data_out0, 8'hFF);
    chk("bo0_count", sample_cnt0, 1);
    frame(8'hA5, 1, 0, 1);
    rdy = 1; tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 1; i <= 5; i++) frame(BA'(i), i == 1, i != 5, 0);
    drain();
    abort_frame(1, 3, 0);
    frame(8'h3C, 0, 0, 0);
    drain();
    frame(8'h80, 1, 0, 0);
    sc = 1; tick(0, 0, 0);
    sc = 0; tick(0, 0, 0);
    repeat (BO + 4) begin
      dout = 1; tick(0, 0, 0);
    end
    xrst = 0;
    q.delete(); exp_cnt = 0; exp_ovf = 0;
    #1;
    chk("rst_mid_data", data_out, 0);
    check_all(0);
    @(posedge clk); @(posedge clk); #1 xrst = 1;
    frame(8'hC3, 1, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) frame(8'h10 + BA'(i), 1, 0, 0);
    frame(8'h55, 1, 0, 3);
    drain();
    for (int i = 0; i < 5; i++) frame(8'h20 + BA'(i), 1, 0, 0);
    clr = 1; tick(0, 0, 0); clr = 0;
    frame(8'h99, 1, 0, 4);
    drain();
    clr = 1; tick(0, 0, 0); clr = 0;
    hi = 0;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 5) == 0) begin
        abort_frame(!hi, $urandom_range(0, BA - 1), 2);
        hi = 1;
      end else begin
        w = BA'($urandom);
        frame(w, !hi, 1'($urandom), 2);
        hi = sc;
      end
    end
    sc = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/sar_word_collector.md
# sar_word_collector

Downstream companion of the SAR logic: collects the serial, MSB-first conversion result the SAR logic drives on its digital output during each conversion frame and assembles it into a parallel BIT_ADC-bit word. Frame boundaries come from the SAR sample-control signal. Completed words enter a small first-word-fall-through FIFO with a valid/ready read port toward the system side. The block adds a sticky overflow flag, a frame-abort error pulse and a running count of accepted samples.

## Interface

Parameters:
- BIT_ADC, 8: resolution; bits per conversion word.
- BIT_OFFSET, 1: CLK edges skipped after the frame start before the first result bit is captured; range 0..15.
- FIFO_DEPTH, 4: word storage depth; power of two, at least 2.

Ports:
- CLK  in  1  single clock, rising-edge.
- XRST  in  1  asynchronous, active-low reset.
- SAR_SC  in  1  SAR sample control; high = sampling, falling edge starts conversion.
- SAR_DOUT  in  1  SAR serial result bit, MSB first.
- DATA_OUT  out  BIT_ADC  FIFO head word.
- DATA_VALID  out  1  FIFO non-empty.
- DATA_READY  in  1  consumer accepts head when DATA_VALID && DATA_READY at a rising edge.
- OVERFLOW  out  1  sticky: a completed word was dropped.
- CLR_OVF  in  1  synchronous clear of OVERFLOW.
- FRAME_ERR  out  1  one-cycle pulse: frame aborted.
- SAMPLE_CNT  out  16  number of words accepted into the FIFO, wraps.

## Operation

- FSM states: IDLE, SAMPLE, SKIP, SHIFT, PUSH.
- IDLE: wait for SAR_SC sampled high, then go to SAMPLE. Reset always enters IDLE, so a frame already in progress at reset release is ignored.
- SAMPLE: at the first edge with SAR_SC sampled low (edge t0), go to SKIP. If BIT_OFFSET = 0, go straight to SHIFT.
- SKIP: count BIT_OFFSET edges, then go to SHIFT.
- SHIFT: each edge shifts SAR_DOUT into the LSB of the shift register, MSB first. After BIT_ADC captures, go to PUSH.
- PUSH: write the assembled word to the FIFO, then return to SAMPLE if SAR_SC is high, otherwise to IDLE.
- Abort: SAR_SC sampled high in SKIP or SHIFT.
  - Discard the partial word.
  - Pulse FRAME_ERR for one cycle.
  - Go to SAMPLE.
  - SAMPLE_CNT is unchanged.
- FIFO write when full:
  - If a pop occurs on the same edge, the pop and push both happen and occupancy is unchanged.
  - Otherwise the new word is dropped, OVERFLOW is set, and SAMPLE_CNT is not incremented.
- Pop with the FIFO empty is ignored.
- SAMPLE_CNT increments only on an accepted push and wraps from 0xFFFF to 0x0000.
- OVERFLOW: CLR_OVF clears it. If a set and a clear occur on the same edge, set wins.
- Reset values:
  - DATA_OUT = 0, DATA_VALID = 0, OVERFLOW = 0, FRAME_ERR = 0, SAMPLE_CNT = 0.
  - FIFO empty, shift register 0, state IDLE.

## Timing

- t0 is the edge where SAR_SC is first sampled low.
- Bit k (k = 0 is the MSB) is captured at edge t0 + BIT_OFFSET + 1 + k.
- The last bit is captured at edge L = t0 + BIT_OFFSET + BIT_ADC.
- The FIFO write happens at edge L+1. If the FIFO was empty, DATA_VALID and DATA_OUT are valid immediately after L+1.
- Total latency from t0 to DATA_VALID is BIT_OFFSET + BIT_ADC + 1 edges.
- DATA_OUT and DATA_VALID are registered, with no combinational path from DATA_READY.
- After a pop, the next word appears in the following cycle.
- Minimum frame spacing: a new SAR_SC high is accepted at the PUSH edge itself, so frames can run back-to-back.
- FRAME_ERR is asserted in the cycle after the abort edge.

## Structure

- Shared package sar_pkg holds:
  - BIT_ADC default.
  - FSM state enum: IDLE, SAMPLE, SKIP, SHIFT, PUSH.
  - SAMPLE_CNT width constant (16).
- One sub-module: sar_word_fifo. It is parameterized by width and depth, with push, full, pop, empty and head signals, and implements the simultaneous push/pop-when-full rule.
- The top level contains the FSM, the skip/bit counters, the shift register, the overflow and error logic, and the sample counter.

## Test plan

Default parameters (BIT_ADC = 8, BIT_OFFSET = 1, FIFO_DEPTH = 4) unless stated.

- Single frame with 0xA5 on SAR_DOUT, DATA_READY = 1 → DATA_OUT = 0xA5 with DATA_VALID for one cycle after edge t0+10; SAMPLE_CNT = 1.
- Five back-to-back frames 0x01..0x05, DATA_READY = 0 → FIFO holds 0x01..0x04; OVERFLOW = 1; SAMPLE_CNT = 4. Then DATA_READY = 1 → pops 0x01, 0x02, 0x03, 0x04 in order, then DATA_VALID = 0.
- FIFO full, DATA_READY = 1 on the PUSH edge of frame 0x55 → no drop; OVERFLOW stays 0; occupancy stays 4; 0x55 is last out.
- SAR_SC rises after 3 captured bits → FRAME_ERR pulses once; no FIFO write; the next full frame 0x3C is collected correctly.
- XRST asserted during SHIFT while 0x80 already sits in the FIFO → all outputs return to reset values; the FIFO is empty; the first frame after release is captured correctly.
- BIT_OFFSET = 0, frame 0xFF → first bit captured at t0+1; DATA_VALID high after t0+9.
